rr_priority_arbiter: RTL and testbench

// Registered, parametrised successor to the combinational priority encoder.

---
 rtl/rr_priority_arbiter.sv | 113 +++++++++++
 tb/tb_rr_priority_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter.sv
// Registered arbiter: fixed highest-index priority or round-robin with optional lock.
// Winner is presented one cycle after sampling on a valid/ready grant port.
module rr_priority_arbiter #(
    parameter int unsigned IN_WIDTH = 8,
    localparam int unsigned OUT_WIDTH = $clog2(IN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  req,
    input  logic                 mode,
    input  logic                 lock,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_idx,
    output logic [IN_WIDTH-1:0]  out_onehot
);

    logic                 valid_q, valid_d;
    logic [OUT_WIDTH-1:0] idx_q, idx_d;
    logic [IN_WIDTH-1:0]  onehot_q, onehot_d;
    logic [OUT_WIDTH-1:0] ptr_q, ptr_d;

    logic                 cap;
    logic                 any_req;
    logic                 lock_hit;
    logic [OUT_WIDTH-1:0] fix_idx;
    logic [OUT_WIDTH-1:0] rr_idx;
    logic [OUT_WIDTH-1:0] win_idx;
    logic [IN_WIDTH-1:0]  win_onehot;
    logic [OUT_WIDTH-1:0] cand_idx;
    int unsigned          cand;

    assign cap      = !valid_q || out_ready;
    assign any_req  = |req;
    assign lock_hit = mode && lock && req[ptr_q];

    // Highest set index wins: later iterations overwrite earlier ones.
    always_comb begin
        fix_idx = '0;
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            if (req[i]) begin
                fix_idx = OUT_WIDTH'(i);
            end
        end
    end

    // Walk offsets from farthest to nearest so the nearest requester below ptr wins.
    always_comb begin
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = IN_WIDTH; k >= 1; k--) begin
            cand = 32'(ptr_q) + IN_WIDTH - k;
            if (cand >= IN_WIDTH) begin
                cand = cand - IN_WIDTH;
            end
            cand_idx = OUT_WIDTH'(cand);
            if (req[cand_idx]) begin
                rr_idx = cand_idx;
            end
        end
    end

    always_comb begin
        win_idx = fix_idx;
        if (lock_hit) begin
            win_idx = ptr_q;
        end else if (mode) begin
            win_idx = rr_idx;
        end
        win_onehot = {{(IN_WIDTH-1){1'b0}}, 1'b1} << win_idx;
    end

    always_comb begin
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        ptr_d    = ptr_q;
        if (cap) begin
            if (any_req) begin
                valid_d  = 1'b1;
                idx_d    = win_idx;
                onehot_d = win_onehot;
                if (mode) begin
                    ptr_d = win_idx;
                end
            end else begin
                valid_d  = 1'b0;
                idx_d    = '0;
                onehot_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            ptr_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            ptr_q    <= ptr_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench for rr_priority_arbiter (IN_WIDTH=8): expected grants are
// queued when inputs are driven and compared after the capturing edge.
module tb_rr_priority_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] req;
    logic         mode;
    logic         lock;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_idx;
    logic [W-1:0] out_onehot;

    typedef struct {
        bit valid;
        int idx;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit m_valid;
    int m_idx;
    int m_ptr;

    rr_priority_arbiter #(
        .IN_WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mode      (mode),
        .lock      (lock),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_onehot(out_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit req_bit(input logic [W-1:0] r, input int i);
        return ((r >> i) & 1) != 0;
    endfunction

    task automatic model_capture(input logic [W-1:0] r, input logic m, input logic l,
                                 input logic rdy);
        exp_t e;
        int   w;
        if (!m_valid || rdy) begin
            if (r == '0) begin
                m_valid = 1'b0;
                m_idx   = 0;
            end else begin
                w = -1;
                if (m && l && req_bit(r, m_ptr)) begin
                    w = m_ptr;
                end else if (m) begin
                    for (int k = 1; k <= W && w < 0; k++) begin
                        if (req_bit(r, (m_ptr - k + W) % W)) w = (m_ptr - k + W) % W;
                    end
                end else begin
                    for (int i = W - 1; i >= 0 && w < 0; i--) begin
                        if (req_bit(r, i)) w = i;
                    end
                end
                m_valid = 1'b1;
                m_idx   = w;
                if (m) m_ptr = w;
            end
        end
        e.valid = m_valid;
        e.idx   = m_idx;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [W-1:0] r, input logic m, input logic l, input logic rdy);
        exp_t e;
        req       = r;
        mode      = m;
        lock      = l;
        out_ready = rdy;
        model_capture(r, m, l, rdy);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("valid", 32'(out_valid), 32'(e.valid));
        check_eq("idx", 32'(out_idx), e.idx);
        check_eq("onehot", 32'(out_onehot), e.valid ? (32'd1 << e.idx) : 32'd0);
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(out_valid), 0);
        check_eq("rst_idx", 32'(out_idx), 0);
        check_eq("rst_onehot", 32'(out_onehot), 0);
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        mode      = 1'b0;
        lock      = 1'b0;
        out_ready = 1'b0;
        m_valid   = 1'b0;
        m_idx     = 0;
        m_ptr     = 0;
        @(posedge clk);
        #1;
        check_eq("init_valid", 32'(out_valid), 0);
        check_eq("init_onehot", 32'(out_onehot), 0);
        rst_n = 1'b1;

        // Reset while a grant is held, then first round-robin grant
        step(8'hFF, 1'b1, 1'b0, 1'b0);
        check_eq("pre_rst_valid", 32'(out_valid), 1);
        do_reset();
        step(8'hFF, 1'b1, 1'b0, 1'b1);
        check_eq("rst_first_rr", 32'(out_idx), 7);

        // Fixed priority
        for (int i = 0; i < 3; i++) begin
            step(8'b0010_0110, 1'b0, 1'b0, 1'b1);
            check_eq("fixed_idx5", 32'(out_idx), 5);
            check_eq("fixed_oh20", 32'(out_onehot), 32'h20);
        end

        // Round-robin rotation from a fresh pointer
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(8'hFF, 1'b1, 1'b0, 1'b1);
            check_eq("rr_seq", 32'(out_idx), (15 - i) % 8);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(8'h81, 1'b1, 1'b0, 1'b1);
            check_eq("rr_81", 32'(out_idx), (i % 2 == 0) ? 7 : 0);
        end

        // Backpressure: held grant ignores req changes
        step(8'h80, 1'b0, 1'b0, 1'b1);
        step(8'h80, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(8'h01, 1'b0, 1'b0, 1'b0);
            check_eq("bp_hold", 32'(out_idx), 7);
        end
        step(8'h01, 1'b0, 1'b0, 1'b1);
        check_eq("bp_next", 32'(out_idx), 0);

        // Lock
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(8'h0C, 1'b1, 1'b1, 1'b1);
            check_eq("lock_3", 32'(out_idx), 3);
        end
        for (int i = 0; i < 3; i++) begin
            step(8'h0C, 1'b1, 1'b0, 1'b1);
            check_eq("unlock_seq", 32'(out_idx), (i == 1) ? 3 : 2);
        end
        step(8'h30, 1'b1, 1'b1, 1'b1);
        check_eq("lock_miss", 32'(out_idx), 5);

        // Empty request at an accept edge
        step(8'h00, 1'b1, 1'b0, 1'b1);
        check_eq("empty_valid", 32'(out_valid), 0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] r;
            r = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            step(r, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
